// File: rtl/top_level_if.sv
// Memory port between the s_proc_v1 core and its companion 256x16 ram.
interface top_level_if;
    logic [15:0] din;
    logic [7:0]  dout;
    logic [7:0]  adrs;
    logic        rw;

    modport master (
        input  din,
        output dout,
        output adrs,
        output rw
    );

    modport slave (
        output din,
        input  dout,
        input  adrs,
        input  rw
    );
endinterface

// File: rtl/top_level.sv
// s_proc_v1: 8-bit accumulator core, two-clock FETCH/EXEC sequencing.
// Define TOPLEVEL_HALTED_EN to add the halted status output.
module top_level #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        clr,
    top_level_if.master bus
`ifdef TOPLEVEL_HALTED_EN
    ,
    output logic        halted
`endif
);
    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_NOT = 4'hC;
    localparam logic [3:0] OP_SHL = 4'hD;
    localparam logic [3:0] OP_SHR = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t      state, state_next;
    logic [7:0]  pc, pc_next;
    logic [15:0] ir, ir_next;
    logic [7:0]  acc, acc_next;
    logic        z, z_next;
    logic        c, c_next;
    logic        upd_z;

    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  m;
    logic [8:0]  sum;
    logic [8:0]  diff;
    logic        unused_bits;

    assign op   = ir[15:12];
    assign a    = ir[7:0];
    assign m    = bus.din[7:0];
    assign sum  = {1'b0, acc} + {1'b0, m};
    assign diff = {1'b0, acc} - {1'b0, m};

    assign unused_bits = &{1'b0, ir[11:8]};

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
            acc   <= 8'h00;
            z     <= 1'b0;
            c     <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
            acc   <= acc_next;
            z     <= z_next;
            c     <= c_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        acc_next   = acc;
        z_next     = z;
        c_next     = c;
        upd_z      = 1'b0;
        unique case (state)
            FETCH: begin
                ir_next    = bus.din;
                pc_next    = pc + 8'd1;
                state_next = EXEC;
            end
            EXEC: begin
                state_next = FETCH;
                unique case (op)
                    OP_NOP: ;
                    OP_LDA: begin
                        acc_next = m;
                        upd_z    = 1'b1;
                    end
                    OP_STA: ;
                    OP_ADD: begin
                        {c_next, acc_next} = sum;
                        upd_z = 1'b1;
                    end
                    OP_SUB: begin
                        {c_next, acc_next} = diff;
                        upd_z = 1'b1;
                    end
                    OP_AND: begin
                        acc_next = acc & m;
                        upd_z    = 1'b1;
                    end
                    OP_OR: begin
                        acc_next = acc | m;
                        upd_z    = 1'b1;
                    end
                    OP_XOR: begin
                        acc_next = acc ^ m;
                        upd_z    = 1'b1;
                    end
                    OP_LDI: begin
                        acc_next = a;
                        upd_z    = 1'b1;
                    end
                    OP_JMP: pc_next = a;
                    OP_JZ:  if (z) pc_next = a;
                    OP_JC:  if (c) pc_next = a;
                    OP_NOT: begin
                        acc_next = ~acc;
                        upd_z    = 1'b1;
                    end
                    OP_SHL: begin
                        c_next   = acc[7];
                        acc_next = {acc[6:0], 1'b0};
                        upd_z    = 1'b1;
                    end
                    OP_SHR: begin
                        c_next   = acc[0];
                        acc_next = {1'b0, acc[7:1]};
                        upd_z    = 1'b1;
                    end
                    OP_HLT: state_next = HALT;
                    default: ;
                endcase
            end
            HALT: ;
            default: state_next = FETCH;
        endcase
        if (upd_z) begin
            z_next = (acc_next == 8'h00);
        end
    end

    // clr overrides rw so a reset landing on a STA never writes
    assign bus.rw   = clr | ~((state == EXEC) && (op == OP_STA));
    assign bus.adrs = (state == EXEC) ? a : pc;
    assign bus.dout = acc;

`ifdef TOPLEVEL_HALTED_EN
    assign halted = (state == HALT) && !clr;
`endif
endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: ram model, ISA-level
// reference model with per-cycle compare, directed programs.
module tb_top_level;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    top_level_if bus ();

`ifdef TOPLEVEL_HALTED_EN
    logic halted;
`endif

    top_level dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
`ifdef TOPLEVEL_HALTED_EN
        ,
        .halted (halted)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int cyc     = 0;

    logic [15:0] ram [256];
    logic        ld_clear = 1'b0;
    logic        ld_en    = 1'b0;
    logic [7:0]  ld_adr   = 8'h00;
    logic [15:0] ld_dat   = 16'h0000;

    assign bus.din = ram[bus.adrs];

    always @(posedge clk) begin
        if (ld_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
        end else if (ld_en) begin
            ram[ld_adr] <= ld_dat;
        end else if (!bus.rw) begin
            ram[bus.adrs] <= {8'h00, bus.dout};
        end
    end

    // Architectural reference: ph 0=fetch, 1=exec, 2=halted
    typedef struct packed {
        logic [7:0]  pc;
        logic [7:0]  acc;
        logic        z;
        logic        c;
        logic [15:0] ir;
        logic [1:0]  ph;
    } arch_t;

    localparam arch_t ARCH_RST = '{8'h00, 8'h00, 1'b0, 1'b0,
                                   16'h0000, 2'd0};

    arch_t       mdl = ARCH_RST;
    logic [15:0] mmem [256];

    function automatic arch_t step(arch_t s, logic [15:0] wpc,
                                   logic [15:0] wa);
        int acc;
        int m;
        int r;
        bit wr;
        acc = int'(s.acc);
        m   = int'(wa[7:0]);
        r   = 0;
        wr  = 1'b0;
        if (s.ph == 2'd0) begin
            s.ir = wpc;
            s.pc = 8'((int'(s.pc) + 1) % 256);
            s.ph = 2'd1;
        end else if (s.ph == 2'd1) begin
            s.ph = 2'd0;
            case (s.ir[15:12])
                4'h1: begin r = m; wr = 1'b1; end
                4'h3: begin
                    r = acc + m;
                    s.c = (r > 255);
                    r = r % 256;
                    wr = 1'b1;
                end
                4'h4: begin
                    s.c = (acc < m);
                    r = (acc - m + 256) % 256;
                    wr = 1'b1;
                end
                4'h5: begin r = acc & m; wr = 1'b1; end
                4'h6: begin r = acc | m; wr = 1'b1; end
                4'h7: begin r = acc ^ m; wr = 1'b1; end
                4'h8: begin r = int'(s.ir[7:0]); wr = 1'b1; end
                4'h9: s.pc = s.ir[7:0];
                4'hA: if (s.z) s.pc = s.ir[7:0];
                4'hB: if (s.c) s.pc = s.ir[7:0];
                4'hC: begin r = 255 - acc; wr = 1'b1; end
                4'hD: begin
                    s.c = (acc >= 128);
                    r = (acc * 2) % 256;
                    wr = 1'b1;
                end
                4'hE: begin
                    s.c = (acc % 2 == 1);
                    r = acc / 2;
                    wr = 1'b1;
                end
                4'hF: s.ph = 2'd2;
                default: ;
            endcase
            if (wr) begin
                s.acc = 8'(r);
                s.z = (r == 0);
            end
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (ld_clear) begin
            for (int i = 0; i < 256; i++) mmem[i] <= 16'h0000;
        end else if (ld_en) begin
            mmem[ld_adr] <= ld_dat;
        end else if (!clr && mdl.ph == 2'd1
                     && mdl.ir[15:12] == 4'h2) begin
            mmem[mdl.ir[7:0]] <= {8'h00, mdl.acc};
        end
        if (clr) begin
            mdl <= ARCH_RST;
            cyc <= 0;
        end else begin
            mdl <= step(mdl, mmem[mdl.pc], mmem[mdl.ir[7:0]]);
            cyc <= cyc + 1;
        end
    end

    task automatic check(string name, logic [15:0] act,
                         logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] e_adrs;
            logic       e_rw;
            e_adrs = (mdl.ph == 2'd1) ? mdl.ir[7:0] : mdl.pc;
            e_rw   = clr || !(mdl.ph == 2'd1
                              && mdl.ir[15:12] == 4'h2);
            check("adrs", 16'(bus.adrs), 16'(e_adrs));
            check("rw", 16'(bus.rw), 16'(e_rw));
            check("dout", 16'(bus.dout), 16'(mdl.acc));
`ifdef TOPLEVEL_HALTED_EN
            check("halted", 16'(halted),
                  16'(!clr && mdl.ph == 2'd2));
`endif
        end
    end

    logic [7:0]  pa [$];
    logic [15:0] pd [$];

    task automatic put(logic [7:0] adr, logic [15:0] dat);
        pa.push_back(adr);
        pd.push_back(dat);
    endtask

    task automatic load_and_reset();
        @(negedge clk); #1;
        clr = 1'b1;
        ld_clear = 1'b1;
        @(negedge clk); #1;
        ld_clear = 1'b0;
        foreach (pa[i]) begin
            ld_en  = 1'b1;
            ld_adr = pa[i];
            ld_dat = pd[i];
            @(negedge clk); #1;
        end
        ld_en = 1'b0;
        @(negedge clk); #1;
        clr = 1'b0;
        pa.delete();
        pd.delete();
    endtask

    task automatic wait_cyc(int n);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (cyc == n) begin
                #1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_cyc: cycle %0d not reached, at %0d",
                 n, cyc);
    endtask

    task automatic check_mem(string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] !== mmem[i]) bad++;
        check(name, 16'(bad), 16'd0);
    endtask

    initial begin
        // accumulate, store, halt
        put(8'h00, 16'h8005);
        put(8'h01, 16'h3010);
        put(8'h02, 16'h2011);
        put(8'h03, 16'hF000);
        put(8'h10, 16'h0003);
        load_and_reset();
        chk_en = 1'b1;
        check("rst_adrs", 16'(bus.adrs), 16'h0000);
        check("rst_rw", 16'(bus.rw), 16'h0001);
        check("rst_dout", 16'(bus.dout), 16'h0000);
        wait_cyc(1);
        check("t1_ldi_adrs", 16'(bus.adrs), 16'h0005);
        wait_cyc(4);
        check("t1_acc", 16'(bus.dout), 16'h0008);
        wait_cyc(5);
        check("t1_sta_rw", 16'(bus.rw), 16'h0000);
        check("t1_sta_adrs", 16'(bus.adrs), 16'h0011);
        check("t1_sta_dout", 16'(bus.dout), 16'h0008);
        wait_cyc(6);
        check("t1_hlt_fetch", 16'(bus.adrs), 16'h0003);
        wait_cyc(7);
`ifdef TOPLEVEL_HALTED_EN
        check("t1_halted_lo", 16'(halted), 16'h0000);
`endif
        wait_cyc(8);
        check("t1_halt_adrs", 16'(bus.adrs), 16'h0004);
`ifdef TOPLEVEL_HALTED_EN
        check("t1_halted_hi", 16'(halted), 16'h0001);
`endif
        wait_cyc(14);
        check("t1_frozen_adrs", 16'(bus.adrs), 16'h0004);
        check("t1_frozen_rw", 16'(bus.rw), 16'h0001);
        check("t1_m11", ram[8'h11], 16'h0008);
        check_mem("t1_mem");

        // add with carry out, JC then JZ taken
        put(8'h00, 16'h80FF);
        put(8'h01, 16'h3010);
        put(8'h02, 16'hB020);
        put(8'h10, 16'h0001);
        put(8'h20, 16'hA030);
        put(8'h30, 16'hF000);
        load_and_reset();
`ifdef TOPLEVEL_HALTED_EN
        check("t2_halted_clr", 16'(halted), 16'h0000);
`endif
        wait_cyc(4);
        check("t2_add_acc", 16'(bus.dout), 16'h0000);
        wait_cyc(6);
        check("t2_jc_target", 16'(bus.adrs), 16'h0020);
        wait_cyc(8);
        check("t2_jz_target", 16'(bus.adrs), 16'h0030);

        // subtract with borrow, JC taken, SHR clears C
        put(8'h00, 16'h8003);
        put(8'h01, 16'h4010);
        put(8'h02, 16'hB008);
        put(8'h08, 16'hE000);
        put(8'h09, 16'hB040);
        put(8'h0A, 16'hF000);
        put(8'h10, 16'h0005);
        put(8'h40, 16'hF000);
        load_and_reset();
        wait_cyc(4);
        check("t3_sub_acc", 16'(bus.dout), 16'h00FE);
        wait_cyc(6);
        check("t3_jc_taken", 16'(bus.adrs), 16'h0008);
        wait_cyc(8);
        check("t3_shr_acc", 16'(bus.dout), 16'h007F);
        wait_cyc(10);
        check("t3_jc_skip", 16'(bus.adrs), 16'h000A);

        // logic ops, shifts, LDA, store of zero
        put(8'h00, 16'h80F0);
        put(8'h01, 16'h5050);
        put(8'h02, 16'h6051);
        put(8'h03, 16'h7052);
        put(8'h04, 16'hC000);
        put(8'h05, 16'hD000);
        put(8'h06, 16'h1053);
        put(8'h07, 16'hD000);
        put(8'h08, 16'h2054);
        put(8'h09, 16'hF000);
        put(8'h50, 16'h003C);
        put(8'h51, 16'h0005);
        put(8'h52, 16'h00FF);
        put(8'h53, 16'h0080);
        put(8'h54, 16'h00AA);
        load_and_reset();
        wait_cyc(4);
        check("t4_and", 16'(bus.dout), 16'h0030);
        wait_cyc(8);
        check("t4_xor", 16'(bus.dout), 16'h00CA);
        wait_cyc(10);
        check("t4_not", 16'(bus.dout), 16'h0035);
        wait_cyc(12);
        check("t4_shl", 16'(bus.dout), 16'h006A);
        wait_cyc(17);
        check("t4_sta_rw", 16'(bus.rw), 16'h0000);
        wait_cyc(19);
        check("t4_m54", ram[8'h54], 16'h0000);
        check_mem("t4_mem");

        // jump to FF then wrap to 00
        put(8'h00, 16'h90FF);
        load_and_reset();
        wait_cyc(2);
        check("t5_fetch_ff", 16'(bus.adrs), 16'h00FF);
        wait_cyc(4);
        check("t5_wrap", 16'(bus.adrs), 16'h0000);

        // reset landing on STA EXEC
        put(8'h00, 16'h8055);
        put(8'h01, 16'h2030);
        put(8'h30, 16'h1234);
        load_and_reset();
        wait_cyc(3);
        check("t6_sta_rw", 16'(bus.rw), 16'h0000);
        check("t6_sta_adrs", 16'(bus.adrs), 16'h0030);
        clr = 1'b1;
        #1;
        check("t6_clr_rw", 16'(bus.rw), 16'h0001);
        @(negedge clk); #1;
        clr = 1'b0;
        #1;
        check("t6_post_adrs", 16'(bus.adrs), 16'h0000);
        check("t6_post_acc", 16'(bus.dout), 16'h0000);
        check("t6_post_rw", 16'(bus.rw), 16'h0001);
        check("t6_m30", ram[8'h30], 16'h1234);
        check_mem("t6_mem");

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
